// File: rtl/matrix_input_loader_pkg.sv
// matrix_input_loader_pkg: shared width constants and assembly state encoding for the matrix loader
package matrix_input_loader_pkg;
  localparam int MATRIX_WORD_W = 96;
  localparam int MATRIX_BYTE_W = 8;
  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;
endpackage

// File: rtl/matrix_input_loader.sv
// matrix_input_loader: packs an LSB-first byte stream into wide words on a valid/ready port (MATRIX_LOADER_CHECKSUM_EN adds an XOR check beat)
module matrix_input_loader
  import matrix_input_loader_pkg::*;
#(
  parameter int WORD_W = MATRIX_WORD_W,
  parameter int BYTE_W = MATRIX_BYTE_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err
);
  localparam int NBYTES = WORD_W / BYTE_W;
`ifdef MATRIX_LOADER_CHECKSUM_EN
  localparam int NBEATS = NBYTES + 1;
`else
  localparam int NBEATS = NBYTES;
`endif
  localparam int CW = $clog2(NBEATS + 1);

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic              acc, last, ok, slot_free, word_done;

  assign slot_free = !out_valid || out_ready;
  assign acc       = in_valid && in_ready;
  assign last      = acc && (cnt == CW'(NBEATS - 1));
  assign word_done = last && ok;

  // current byte merged into the assembly word; a checksum beat leaves it untouched
  always_comb begin
    asm_d = asm_q;
    for (int k = 0; k < NBYTES; k++)
      if (cnt == CW'(k)) asm_d[k*BYTE_W +: BYTE_W] = in_data;
  end

  // assembly state register
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= FILL;
    else state <= state_nx;

  // FULL is entered only when a word completes against an occupied slot
  always_comb
    state_nx = (state == FILL) ? ((word_done && !slot_free) ? FULL : FILL)
                               : (slot_free ? FILL : FULL);

  // in_ready depends on state alone
  always_comb in_ready = (state == FILL);

  // byte counter and assembly register
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      cnt   <= '0;
      asm_q <= '0;
    end else if (acc) begin
      cnt   <= last ? '0 : cnt + 1'b1;
      asm_q <= asm_d;
    end

  // output slot: a held word has priority, then a word completing this cycle
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      out_x     <= '0;
      out_valid <= 1'b0;
    end else if (state == FULL && slot_free) begin
      out_x     <= asm_q;
      out_valid <= 1'b1;
    end else if (word_done && slot_free) begin
      out_x     <= asm_d;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end

`ifdef MATRIX_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum;
  assign ok = (in_data == csum);
  // running XOR of data beats and one-cycle discard pulse
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      csum <= '0;
      err  <= 1'b0;
    end else begin
      err <= last && !ok;
      if (acc) csum <= last ? '0 : csum ^ in_data;
    end
`else
  assign ok  = 1'b1;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_matrix_input_loader.sv
// tb_matrix_input_loader: table-driven and scoreboard checks of the byte-to-word loader
module tb_matrix_input_loader;
  localparam int W = 96;
`ifdef MATRIX_LOADER_CHECKSUM_EN
  localparam int NB = 13;
`else
  localparam int NB = 12;
`endif

  typedef struct {
    logic [7:0]   base;
    logic [7:0]   step;
    logic [W-1:0] exp;
  } vec_t;

  logic         clock = 1'b0, reset_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0]   in_data = '0;
  logic         in_ready, out_valid, err;
  logic [W-1:0] out_x;

  int           tests = 0, fails = 0, cyc = 0, accepts = 0, last_n = 0;
  logic [W-1:0] q[$];
  int           vcyc[$];
  bit           mon_stream = 1'b0;
  logic         pv = 1'b0, pr = 1'b0;
  logic [W-1:0] px = '0;
  vec_t         tbl[5];

  always #5 clock = ~clock;

  matrix_input_loader dut (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_x(out_x), .out_valid(out_valid), .out_ready(out_ready), .err(err)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard, stability and throughput monitor, sampled on the falling edge
  always @(negedge clock) begin
    cyc++;
    if (reset_n) begin
      if (in_valid && in_ready) accepts++;
      if (mon_stream && out_valid) vcyc.push_back(cyc);
      if (pv && !pr) begin
        chk("hold_valid", W'(out_valid), W'(1));
        chk("hold_x", out_x, px);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %h expected none", out_x);
        end else chk("word", out_x, q.pop_front());
      end
    end
    pv = reset_n && out_valid;
    pr = out_ready;
    px = out_x;
  end

  task automatic step_cycle();
    @(posedge clock);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    do begin
      @(negedge clock);
      ok = in_ready;
      step_cycle();
      n++;
    end while (!ok && n < 100);
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: byte %h not accepted in %0d cycles", b, n);
    end
    last_n   = n;
    in_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] base, input logic [7:0] step);
    logic [7:0] b, cs;
    b  = base;
    cs = '0;
    for (int k = 0; k < 12; k++) begin
      send_byte(b);
      cs ^= b;
      b += step;
    end
`ifdef MATRIX_LOADER_CHECKSUM_EN
    send_byte(cs);
`endif
  endtask

  initial begin
    tbl[0] = '{8'h01, 8'h01, 96'h0C0B0A090807060504030201};
    tbl[1] = '{8'h00, 8'h00, 96'h000000000000000000000000};
    tbl[2] = '{8'hFF, 8'h00, 96'hFFFFFFFFFFFFFFFFFFFFFFFF};
    tbl[3] = '{8'h10, 8'h11, 96'hCBBAA9988776655443322110};
    tbl[4] = '{8'hF0, 8'hFF, 96'hE5E6E7E8E9EAEBECEDEEEFF0};

    repeat (2) step_cycle();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) send_byte(8'hA0 + 8'(k));
    reset_n = 1'b0;
    #1;
    chk("rst_valid", W'(out_valid), W'(0));
    chk("rst_ready", W'(in_ready), W'(1));
    chk("rst_x", out_x, '0);
    chk("rst_err", W'(err), W'(0));
    step_cycle();
    reset_n = 1'b1;
    send_byte(8'h55);
    chk("accept_after_reset", W'(last_n), W'(1));
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;

    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      q.push_back(tbl[i].exp);
      send_seq(tbl[i].base, tbl[i].step);
      chk("latency_valid", W'(out_valid), W'(1));
      chk("latency_x", out_x, tbl[i].exp);
      chk("no_err", W'(err), W'(0));
    end
    step_cycle();

    out_ready = 1'b0;
    q.push_back(tbl[0].exp);
    q.push_back(tbl[3].exp);
    send_seq(tbl[0].base, tbl[0].step);
    send_seq(tbl[3].base, tbl[3].step);
    chk("bp_ready_low", W'(in_ready), W'(0));
    chk("bp_valid", W'(out_valid), W'(1));
    chk("bp_first_held", out_x, tbl[0].exp);
    out_ready = 1'b1;
    step_cycle();
    out_ready = 1'b0;
    chk("bp_second_x", out_x, tbl[3].exp);
    chk("bp_second_valid", W'(out_valid), W'(1));
    chk("bp_ready_back", W'(in_ready), W'(1));
    step_cycle();
    out_ready = 1'b1;
    step_cycle();
    chk("bp_drained", W'(out_valid), W'(0));

    begin
      int a0, c0, c1, a1;
      vcyc.delete();
      a0 = accepts;
      c0 = cyc;
      mon_stream = 1'b1;
      for (int i = 0; i < 5; i++) begin
        q.push_back(tbl[4 - i].exp);
        send_seq(tbl[4 - i].base, tbl[4 - i].step);
      end
      c1 = cyc;
      a1 = accepts;
      step_cycle();
      mon_stream = 1'b0;
      chk("stream_accepts", W'(a1 - a0), W'(5 * NB));
      chk("stream_cycles", W'(c1 - c0), W'(5 * NB));
      chk("stream_pulses", W'(vcyc.size()), W'(5));
      for (int i = 1; i < vcyc.size(); i++) chk("stream_spacing", W'(vcyc[i] - vcyc[i-1]), W'(NB));
    end

    for (int k = 0; k < 7; k++) send_byte(8'h40 + 8'(k));
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    chk("midrst_valid", W'(out_valid), W'(0));
    repeat (3) step_cycle();
    chk("midrst_quiet", W'(out_valid), W'(0));
    q.push_back(tbl[0].exp);
    send_seq(tbl[0].base, tbl[0].step);
    chk("midrst_clean_x", out_x, tbl[0].exp);

`ifdef MATRIX_LOADER_CHECKSUM_EN
    step_cycle();
    for (int k = 1; k <= 12; k++) send_byte(8'(k));
    send_byte(8'hFF);
    chk("cs_bad_err", W'(err), W'(1));
    chk("cs_bad_valid", W'(out_valid), W'(0));
    step_cycle();
    chk("cs_err_pulse", W'(err), W'(0));
    q.push_back(tbl[3].exp);
    send_seq(tbl[3].base, tbl[3].step);
    chk("cs_recover_x", out_x, tbl[3].exp);
    chk("cs_recover_err", W'(err), W'(0));
`endif

    for (int k = 0; k < 50 && q.size() != 0; k++) step_cycle();
    chk("drain", W'(q.size()), W'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
